// File: rtl/operand2_encoder.sv
// operand2_encoder: iterative search for the ARM rotated-immediate form {rot[3:0], imm8[7:0]} of a 32-bit constant.
// Optional macro OPERAND2_ENCODER_NEGATE_SEARCH_EN also searches ~value (MVN form) and reports it on inv.
module operand2_encoder #(
    parameter int CHECKS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] value,
    output logic        done_valid,
    input  logic        done_ready,
    output logic        found,
    output logic [11:0] encoding,
    output logic        inv
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] value_q;
    logic [3:0]  cnt;

    logic        hit;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm;
    logic        hit_inv;
    logic        last_block;
    logic [3:0]  rot;
    logic [31:0] rot_pos;
`ifdef OPERAND2_ENCODER_NEGATE_SEARCH_EN
    logic [31:0] rot_neg;
    logic        inv_q;
`endif

    // Rotate left by 2*r: the upper half of the doubled word shifted left.
    function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] t;
        t = {v, v} << {r, 1'b0};
        return t[63:32];
    endfunction

    // Walk the block from the highest rotation down so the lowest match overwrites last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hit     = 1'b0;
        hit_rot = '0;
        hit_imm = '0;
        hit_inv = 1'b0;
        rot     = '0;
        rot_pos = '0;
`ifdef OPERAND2_ENCODER_NEGATE_SEARCH_EN
        rot_neg = '0;
`endif
        for (int i = CHECKS_PER_CYCLE - 1; i >= 0; i--) begin
            rot     = cnt + 4'(i);
            rot_pos = rol2(value_q, rot);
`ifdef OPERAND2_ENCODER_NEGATE_SEARCH_EN
            rot_neg = rol2(~value_q, rot);
            if (rot_neg[31:8] == 24'd0) begin
                hit     = 1'b1;
                hit_rot = rot;
                hit_imm = rot_neg[7:0];
                hit_inv = 1'b1;
            end
`endif
            // Checked after the inverted form so the plain form wins at equal rotation.
            if (rot_pos[31:8] == 24'd0) begin
                hit     = 1'b1;
                hit_rot = rot;
                hit_imm = rot_pos[7:0];
                hit_inv = 1'b0;
            end
        end
    end

    assign last_block = ({1'b0, cnt} + 5'(CHECKS_PER_CYCLE)) == 5'd16;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid)        state_next = SEARCH;
            SEARCH:  if (hit || last_block)  state_next = DONE;
            DONE:    if (done_ready)         state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            value_q  <= '0;
            cnt      <= '0;
            found    <= 1'b0;
            encoding <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        value_q  <= value;
                        cnt      <= '0;
                        found    <= 1'b0;
                        encoding <= '0;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        found    <= 1'b1;
                        encoding <= {hit_rot, hit_imm};
                    end else if (!last_block) begin
                        cnt <= cnt + 4'(CHECKS_PER_CYCLE);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OPERAND2_ENCODER_NEGATE_SEARCH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else if (state == IDLE && start_valid) begin
            inv_q <= 1'b0;
        end else if (state == SEARCH && hit) begin
            inv_q <= hit_inv;
        end
    end

    assign inv = inv_q;
`else
    // hit_inv is only ever 0 here; the inverted search is not built.
    assign inv = hit_inv & 1'b0;
`endif

endmodule
